// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers used by the key expansion and round datapaths.
// S-box values are derived arithmetically (field inverse plus affine map), so no lookup tables are needed.
package aes_pkg;

    localparam int NB   = 4;
    localparam int NK   = 4;
    localparam int NR   = 10;
    localparam int KS_W = 128 * (NR + 1);

    localparam logic [7:0] RCON [0:NR-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; 0 maps to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i lives at bits [127-8i -: 8]; it sits in row i%4, column i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/addRoundKey.sv
// AddRoundKey step: bitwise XOR of the 128-bit state with a round key.
module addRoundKey (
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    output logic [127:0] data_out
);

    assign data_out = data_in ^ round_key;

endmodule

// File: rtl/aes128_key_expand.sv
// Combinational AES-128 key expansion; round key r occupies [KS_W-1-128r -: 128].
module aes128_key_expand
    import aes_pkg::*;
(
    input  logic [127:0]     key,
    output logic [KS_W-1:0]  key_schedule
);

    always_comb begin
        logic [127:0] rk;
        logic [31:0]  t;
        logic [31:0]  n0, n1, n2, n3;
        key_schedule = '0;
        rk = key;
        key_schedule[KS_W - 1 -: 128] = rk;
        for (int r = 1; r <= NR; r++) begin
            t  = sub_word({rk[23:0], rk[31:24]}) ^ {RCON[r - 1], 24'h000000};
            n0 = rk[127:96] ^ t;
            n1 = rk[95:64]  ^ n0;
            n2 = rk[63:32]  ^ n1;
            n3 = rk[31:0]   ^ n2;
            rk = {n0, n1, n2, n3};
            key_schedule[KS_W - 1 - 128 * r -: 128] = rk;
        end
    end

endmodule

// File: rtl/decryptLastRound.sv
// Final inverse round: same as a full round but without InvMixColumns.
module decryptLastRound
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);

    logic [127:0] sub_out;

    assign sub_out = inv_sub_bytes(inv_shift_rows(state_in));

    addRoundKey u_ark (
        .data_in  (sub_out),
        .round_key(round_key),
        .data_out (state_out)
    );

endmodule

// File: rtl/decryptRound.sv
// One full inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
module decryptRound
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);

    logic [127:0] sub_out;
    logic [127:0] key_out;

    assign sub_out = inv_sub_bytes(inv_shift_rows(state_in));

    addRoundKey u_ark (
        .data_in  (sub_out),
        .round_key(round_key),
        .data_out (key_out)
    );

    assign state_out = inv_mix_columns(key_out);

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 decryptor: initial AddRoundKey, nine inverse rounds, one final round, one per clock.
// A new block is started only by pulsing reset; after the last round the result is held.
module aes128_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] Message,
    input  logic [127:0] Key,
    output logic [127:0] decipher,
    output logic         done
);

    localparam logic [3:0] CNT_FIRST = 4'd0;
    localparam logic [3:0] CNT_LAST  = 4'd10;
    localparam logic [3:0] CNT_DONE  = 4'd11;

    logic [KS_W-1:0] keySchedule;
    logic [3:0]      cnt_q, cnt_d;
    logic [127:0]    state_q, state_d;
    logic            done_q, done_d;
    logic [3:0]      round_idx;
    logic [127:0]    round_key;
    logic [127:0]    ark_out, mid_out, last_out;

    aes128_key_expand u_key_expand (
        .key         (Key),
        .key_schedule(keySchedule)
    );

    // cnt=0 uses rk10; cnt=1..10 uses rk(10-cnt).
    always_comb begin
        round_idx = 4'(NR);
        if (cnt_q > CNT_LAST) begin
            round_idx = '0;
        end else if (cnt_q != CNT_FIRST) begin
            round_idx = 4'(NR) - cnt_q;
        end
        round_key = keySchedule[KS_W - 1 -: 128];
        for (int r = 0; r <= NR; r++) begin
            if (round_idx == 4'(r)) round_key = keySchedule[KS_W - 1 - 128 * r -: 128];
        end
    end

    addRoundKey u_ark_first (
        .data_in  (Message),
        .round_key(round_key),
        .data_out (ark_out)
    );

    decryptRound u_round (
        .state_in (state_q),
        .round_key(round_key),
        .state_out(mid_out)
    );

    decryptLastRound u_last (
        .state_in (state_q),
        .round_key(round_key),
        .state_out(last_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (cnt_q == CNT_FIRST) begin
            state_d = ark_out;
            cnt_d   = cnt_q + 4'd1;
        end else if (cnt_q < CNT_LAST) begin
            state_d = mid_out;
            cnt_d   = cnt_q + 4'd1;
        end else if (cnt_q == CNT_LAST) begin
            state_d = last_out;
            cnt_d   = CNT_DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            cnt_q   <= CNT_FIRST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign decipher = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Bench for aes128_decrypt: FIPS-197 vectors, reset abort/hold behaviour and random blocks
// compared round by round against a table-driven inverse-cipher model.
module tb_aes128_decrypt;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] Message = '0;
    logic [127:0] Key = '0;
    logic [127:0] decipher;
    logic         done;

    always #5 clk = ~clk;

    aes128_decrypt dut (
        .clk     (clk),
        .reset   (reset),
        .Message (Message),
        .Key     (Key),
        .decipher(decipher),
        .done    (done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]   sb   [256];
    logic [7:0]   isb  [256];
    logic [7:0]   gexp [256];
    logic [7:0]   glog [256];
    logic [7:0]   mdl  [4][4];
    logic [127:0] exp_rk [11];
    logic [127:0] exp_q [$];

    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_R1    = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(int'(glog[a]) + int'(glog[b])) % 255];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++)
            y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        return y ^ 8'h63;
    endfunction

    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] inv;
        p = 8'h01;
        for (int k = 0; k < 255; k++) begin
            gexp[k] = p;
            glog[p] = 8'(k);
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        gexp[255] = 8'h01;
        glog[0]   = 8'h00;
        sb[0] = 8'h63;
        for (int a = 1; a < 256; a++) begin
            inv = gexp[(255 - int'(glog[a])) % 255];
            sb[a] = affine(inv);
        end
        for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
    endtask

    function automatic logic [127:0] pack_state();
        logic [127:0] v;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v[127 - 8 * (r + 4 * c) -: 8] = mdl[r][c];
        return v;
    endfunction

    task automatic add_key(input int rnd);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mdl[r][c] = mdl[r][c] ^ exp_rk[rnd][127 - 8 * (r + 4 * c) -: 8];
    endtask

    task automatic shift_sub();
        logic [7:0] tmp [4][4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tmp[r][(c + r) % 4] = mdl[r][c];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mdl[r][c] = isb[tmp[r][c]];
    endtask

    task automatic mix();
        logic [7:0] col [4];
        logic [7:0] coef [4];
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) col[r] = mdl[r][c];
            for (int r = 0; r < 4; r++) begin
                mdl[r][c] = 8'h00;
                for (int k = 0; k < 4; k++)
                    mdl[r][c] = mdl[r][c] ^ mul(coef[(k - r + 4) % 4], col[k]);
            end
        end
    endtask

    // Fills exp_rk and pushes the expected state after each of the 11 edges.
    task automatic model_run(input logic [127:0] key, input logic [127:0] msg);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mdl[r][c] = msg[127 - 8 * (r + 4 * c) -: 8];
        exp_q.delete();
        add_key(10);
        exp_q.push_back(pack_state());
        for (int rnd = 9; rnd >= 1; rnd--) begin
            shift_sub();
            add_key(rnd);
            mix();
            exp_q.push_back(pack_state());
        end
        shift_sub();
        add_key(0);
        exp_q.push_back(pack_state());
    endtask

    // ---------------- driver ----------------
    task automatic start_block(input logic [127:0] key, input logic [127:0] msg);
        @(negedge clk);
        reset   = 1'b1;
        Key     = key;
        Message = msg;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] msg);
        logic [127:0] expv;
        model_run(key, msg);
        start_block(key, msg);
        for (int r = 0; r < 11; r++)
            check($sformatf("%s_rk%0d", tag, r), dut.keySchedule[1407 - 128 * r -: 128], exp_rk[r]);
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            @(negedge clk);
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check($sformatf("%s_edge%0d", tag, e), decipher, expv);
            check_bit($sformatf("%s_done%0d", tag, e), done, e == 11);
        end
    endtask

    initial begin
        build_tables();

        // Reset held across several edges: nothing moves.
        Key     = C1_KEY;
        Message = C1_CT;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_state", decipher, '0);
            check_bit("rst_hold_done", done, 1'b0);
            check("rst_hold_cnt", {124'b0, dut.cnt_q}, '0);
        end

        // FIPS C.1 with model comparison every edge, plus published constants.
        run_block("c1", C1_KEY, C1_CT);
        check("c1_plain", decipher, C1_PT);
        check("c1_rk10", dut.keySchedule[127:0], C1_RK10);

        // FIPS B.
        run_block("fb", B_KEY, B_CT);
        check("fb_plain", decipher, B_PT);
        check("fb_rk10", dut.keySchedule[127:0], B_RK10);

        // Abort at edge 5 of a C.1 run, then restart.
        start_block(C1_KEY, C1_CT);
        @(posedge clk);
        @(negedge clk);
        check("abort_edge1", decipher, C1_R1);
        check_bit("abort_edge1_done", done, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_async_state", decipher, '0);
        check_bit("abort_async_done", done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_held_state", decipher, '0);
        check("abort_held_cnt", {124'b0, dut.cnt_q}, '0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_bit("restart_edge10_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("restart_plain", decipher, C1_PT);
        check_bit("restart_done", done, 1'b1);

        // Hold after done.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold%0d_state", i), decipher, C1_PT);
            check_bit($sformatf("hold%0d_done", i), done, 1'b1);
        end

        // Random blocks.
        for (int n = 0; n < 6; n++) begin
            logic [127:0] rk;
            logic [127:0] rm;
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rm = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block($sformatf("rand%0d", n), rk, rm);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
